// File: rtl/neosd_wb_arbiter.sv
// neosd_wb_arbiter: two-master Wishbone arbiter in front of the neosd register
// slave. M0 is the CPU, M1 is the SD block-transfer DMA engine. One master
// owns the slave for a complete Wishbone cycle (cyc high), with round-robin
// selection on ties and a watchdog that aborts transfers neosd never acks.
//
// Build option: define NEOSD_ARB_FIXED_PRIO_EN to make M0 always win a tie
// (the round-robin history register is then removed).
//
// Handshake: Wishbone classic. A master requests the bus with cyc and marks
// each transfer with stb; a transfer completes in the cycle where stb and ack
// are both high. err replaces ack for a transfer the watchdog gave up on.
// cyc of a master that is not granted is simply held off; it has no effect on
// the slave until that master is granted.

module neosd_wb_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // master 0 (CPU)
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [31:0]       m0_dat_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_sel_i,
    input  logic              m0_stb_i,
    input  logic              m0_cyc_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    output logic [31:0]       m0_dat_o,
    // master 1 (DMA)
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [31:0]       m1_dat_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_sel_i,
    input  logic              m1_stb_i,
    input  logic              m1_cyc_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [31:0]       m1_dat_o,
    // slave (neosd)
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [31:0]       s_dat_o,
    output logic              s_we_o,
    output logic [3:0]        s_sel_o,
    output logic              s_stb_o,
    output logic              s_cyc_o,
    input  logic              s_ack_i,
    input  logic [31:0]       s_dat_i,
    // debug: one-hot current grant
    output logic [1:0]        grant_o
);

    // Watchdog counter is wide enough to hold TIMEOUT itself, so saturation
    // at TIMEOUT never wraps back to zero.
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    // Master whose transfer is being aborted (0 = M0, 1 = M1).
    logic             abort_m;
    logic             abort_m_next;
    // Tie-break choice made in IDLE: 1 selects M1.
    logic             pick_m1;
    logic             timeout_hit;

`ifndef NEOSD_ARB_FIXED_PRIO_EN
    // Master that owned the bus most recently (0 = M0, 1 = M1).
    logic             last_grant;
    logic             last_grant_next;
`endif

    // Arbitration choice used when leaving IDLE.
    always_comb begin
`ifdef NEOSD_ARB_FIXED_PRIO_EN
        pick_m1 = m1_cyc_i && !m0_cyc_i;
`else
        pick_m1 = m1_cyc_i && (!m0_cyc_i || !last_grant);
`endif
    end

    // Bus forwarding: only the granted master reaches the slave and sees ack.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        grant_o  = 2'b00;
        case (state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                grant_o  = 2'b01;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                grant_o  = 2'b10;
            end
            ABORT: begin
                // Slave is released; a late ack from neosd is dropped here.
                m0_err_o = !abort_m;
                m1_err_o = abort_m;
            end
            default: ;
        endcase
    end

    // Watchdog fires when the last allowed stalled cycle passes without ack.
    always_comb begin
        timeout_hit = s_stb_o && !s_ack_i && (cnt == CNT_LAST);
    end

    // Next-state logic: grant per cycle, hold while cyc stays high.
    always_comb begin
        state_next   = state;
        abort_m_next = abort_m;
`ifndef NEOSD_ARB_FIXED_PRIO_EN
        last_grant_next = last_grant;
`endif
        case (state)
            IDLE: begin
                if (m0_cyc_i || m1_cyc_i) begin
                    state_next = pick_m1 ? GNT1 : GNT0;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_next = IDLE;
`ifndef NEOSD_ARB_FIXED_PRIO_EN
                    last_grant_next = 1'b0;
`endif
                end else if (timeout_hit) begin
                    state_next   = ABORT;
                    abort_m_next = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_next = IDLE;
`ifndef NEOSD_ARB_FIXED_PRIO_EN
                    last_grant_next = 1'b1;
`endif
                end else if (timeout_hit) begin
                    state_next   = ABORT;
                    abort_m_next = 1'b1;
                end
            end
            ABORT: begin
                state_next = IDLE;
`ifndef NEOSD_ARB_FIXED_PRIO_EN
                last_grant_next = abort_m;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Watchdog counter: counts consecutive stalled cycles of one grant.
    always_comb begin
        cnt_next = '0;
        if ((state_next == state) && s_stb_o && !s_ack_i) begin
            cnt_next = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
        end
    end

    // State, watchdog and arbitration history registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            abort_m <= 1'b0;
`ifndef NEOSD_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            abort_m <= abort_m_next;
`ifndef NEOSD_ARB_FIXED_PRIO_EN
            last_grant <= last_grant_next;
`endif
        end
    end

endmodule

// File: tb/tb_neosd_wb_arbiter.sv
// tb_neosd_wb_arbiter: directed scenarios followed by random two-master
// traffic, every cycle compared against a transaction-level ownership model.

module tb_neosd_wb_arbiter;

    localparam int TMO = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT signals
    logic [31:0] m0_adr, m1_adr, m0_wdat, m1_wdat, m0_rdat, m1_rdat;
    logic        m0_we, m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic        s_we, s_stb, s_cyc, s_ack;
    logic [3:0]  s_sel;
    logic [1:0]  grant;

    neosd_wb_arbiter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m0_dat_o(m0_rdat),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .m1_dat_o(m1_rdat),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack), .s_dat_i(s_rdat),
        .grant_o(grant)
    );

    // scoreboard state
    int checks = 0;
    int failures = 0;
    logic [1:0] exp_q[$];
    logic [1:0] prev_grant = 2'b00;

    // reference model: who owns the bus, pending abort, history, stall length
    int   mdl_owner;
    int   mdl_abort;
    logic mdl_last;
    int   mdl_stall;

    // values seen in the most recent cycle
    logic [1:0]  exp_ack_g, exp_err_g;
    logic [1:0]  o_grant, o_ack, o_err;
    logic        o_scyc, o_sstb;
    logic [31:0] o_sdat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick_winner(input logic c0, input logic c1, input logic last);
`ifdef NEOSD_ARB_FIXED_PRIO_EN
        if (c0) return 0;
        return (c1 && last) ? 1 : 1;
`else
        if (c0 && c1) return last ? 0 : 1;
        return c0 ? 0 : 1;
`endif
    endfunction

    // Advance the model by one clock using the inputs of the current cycle.
    task automatic model_step();
        logic cyc_k, stb_k;
        if (rst) begin
            mdl_owner = -1; mdl_abort = -1; mdl_last = 1'b1; mdl_stall = 0;
        end else if (mdl_abort >= 0) begin
            mdl_last  = (mdl_abort == 1);
            mdl_abort = -1;
            mdl_stall = 0;
        end else if (mdl_owner < 0) begin
            if (m0_cyc || m1_cyc) begin
                mdl_owner = pick_winner(m0_cyc, m1_cyc, mdl_last);
                mdl_stall = 0;
            end
        end else begin
            cyc_k = (mdl_owner == 0) ? m0_cyc : m1_cyc;
            stb_k = (mdl_owner == 0) ? m0_stb : m1_stb;
            if (!cyc_k) begin
                mdl_last  = (mdl_owner == 1);
                mdl_owner = -1;
                mdl_stall = 0;
            end else if (stb_k && !s_ack) begin
                mdl_stall++;
                if (mdl_stall >= TMO) begin
                    mdl_abort = mdl_owner;
                    mdl_owner = -1;
                    mdl_stall = 0;
                end
            end else begin
                mdl_stall = 0;
            end
        end
    endtask

    // One clock: inputs already driven at posedge+1; check, then advance.
    task automatic cycle();
        logic [1:0]  eg, eack, eerr;
        logic        ecyc, estb;
        logic [63:0] edat;
        s_rdat = $urandom;
        #2;
        eg = 2'b00; eack = 2'b00; eerr = 2'b00; ecyc = 1'b0; estb = 1'b0; edat = '0;
        if (mdl_abort == 0) begin
            eerr = 2'b01;
        end else if (mdl_abort == 1) begin
            eerr = 2'b10;
        end else if (mdl_owner == 0) begin
            eg = 2'b01; ecyc = m0_cyc; estb = m0_stb; eack = {1'b0, s_ack};
            edat = {32'h0, s_rdat};
            check("s_req_m0", {s_adr, s_wdat}, {m0_adr, m0_wdat});
            check("s_ctl_m0", 64'({s_we, s_sel}), 64'({m0_we, m0_sel}));
        end else if (mdl_owner == 1) begin
            eg = 2'b10; ecyc = m1_cyc; estb = m1_stb; eack = {s_ack, 1'b0};
            edat = {s_rdat, 32'h0};
            check("s_req_m1", {s_adr, s_wdat}, {m1_adr, m1_wdat});
            check("s_ctl_m1", 64'({s_we, s_sel}), 64'({m1_we, m1_sel}));
        end
        check("grant", 64'(grant), 64'(eg));
        check("s_cyc", 64'(s_cyc), 64'(ecyc));
        check("s_stb", 64'(s_stb), 64'(estb));
        check("ack", 64'({m1_ack, m0_ack}), 64'(eack));
        check("err", 64'({m1_err, m0_err}), 64'(eerr));
        if (mdl_abort < 0) check("m_dat", {m1_rdat, m0_rdat}, edat);
        if (grant != 2'b00 && prev_grant == 2'b00 && exp_q.size() > 0)
            check("grant_order", 64'(grant), 64'(exp_q.pop_front()));
        prev_grant = grant;
        exp_ack_g = eack; exp_err_g = eerr;
        o_grant = grant; o_ack = {m1_ack, m0_ack}; o_err = {m1_err, m0_err};
        o_scyc = s_cyc; o_sstb = s_stb; o_sdat = s_wdat;
        model_step();
        @(posedge clk);
        #1;
    endtask

    // driver: both masters released, slave silent
    task automatic drive_idle();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'hF;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = 4'hF;
        m0_adr = $urandom; m0_wdat = $urandom; m1_adr = $urandom; m1_wdat = $urandom;
        s_ack = 1'b0;
    endtask

    initial begin
        int   req0, req1, n, stb_t, err_t, left0, left1;
        logic ack_seen, stuck;

        // reset
        rst = 1'b1;
        drive_idle();
        s_rdat = '0;
        @(posedge clk);
        #1;
        mdl_owner = -1; mdl_abort = -1; mdl_last = 1'b1; mdl_stall = 0;
        cycle();
        rst = 1'b0;

        // M0 single write, neosd acks after 3 stalled cycles
        m0_adr = 32'h4; m0_wdat = 32'hA5A5_0001; m0_we = 1'b1; m0_sel = 4'hF;
        m0_cyc = 1'b1; m0_stb = 1'b1;
        cycle();
        check("t1_cyc_before_grant", 64'(o_scyc), 64'(0));
        cycle();
        check("t1_cyc_latency", 64'(o_scyc), 64'(1));
        check("t1_grant", 64'(o_grant), 64'(2'b01));
        check("t1_s_dat", 64'(o_sdat), 64'(32'hA5A5_0001));
        cycle();
        cycle();
        s_ack = 1'b1;
        cycle();
        check("t1_ack_with_s_ack", 64'(o_ack), 64'(2'b01));
        drive_idle();
        cycle();
        cycle();

        // simultaneous single reads, 4 rounds, starting from reset history
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            exp_q.push_back(2'b01);
            exp_q.push_back(2'b10);
        end
        for (int r = 0; r < 4; r++) begin
            req0 = 1; req1 = 1; n = 0;
            while ((req0 != 0 || req1 != 0) && n < 20) begin
                m0_cyc = (req0 != 0); m0_stb = (req0 != 0); m0_we = 1'b0;
                m1_cyc = (req1 != 0); m1_stb = (req1 != 0); m1_we = 1'b0;
                s_ack = (mdl_owner == 0 && req0 != 0) || (mdl_owner == 1 && req1 != 0);
                cycle();
                if (exp_ack_g[0]) req0 = 0;
                if (exp_ack_g[1]) req1 = 0;
                n++;
            end
            drive_idle();
            cycle();
        end
        check("t2_grants_seen", 64'(exp_q.size()), 64'(0));
        exp_q.delete();

        // M1 locks the bus for 3 transfers while M0 waits
        drive_idle();
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
        cycle();
        m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_m1_ack_only", 64'(o_ack), 64'(2'b10));
        end
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        cycle();
        check("t3_m0_blocked", 64'(o_ack[0]), 64'(0));
        cycle();
        check("t3_idle_gap", 64'({o_scyc, o_grant}), 64'(0));
        s_ack = 1'b1;
        cycle();
        check("t3_m0_grant", 64'(o_grant), 64'(2'b01));
        check("t3_m0_ack", 64'(o_ack), 64'(2'b01));
        drive_idle();
        cycle();
        cycle();

        // timeout: neosd never acks
        m0_cyc = 1'b1; m0_stb = 1'b1;
        stb_t = -1; err_t = -1; ack_seen = 1'b0;
        for (int i = 0; i < 24; i++) begin
            cycle();
            if (o_sstb && stb_t < 0) stb_t = i;
            if (o_ack[0]) ack_seen = 1'b1;
            if (o_err[0]) begin
                err_t = i;
                check("t4_cyc_in_err", 64'(o_scyc), 64'(0));
                break;
            end
        end
        check("t4_err_delay", 64'(err_t - stb_t), 64'(TMO));
        check("t4_no_ack", 64'(ack_seen), 64'(0));
        drive_idle();
        cycle();
        check("t4_err_single", 64'(o_err), 64'(0));

        // ack on the last allowed stalled cycle wins over the timeout
        m0_cyc = 1'b1; m0_stb = 1'b1;
        cycle();
        for (int i = 0; i < TMO - 1; i++) cycle();
        s_ack = 1'b1;
        cycle();
        check("t5_ack_wins", 64'(o_ack), 64'(2'b01));
        check("t5_no_err", 64'(o_err), 64'(0));
        drive_idle();
        cycle();
        check("t5_no_abort", 64'(o_err), 64'(0));
        s_ack = 1'b1;
        cycle();
        check("t5_late_ack", 64'(o_ack), 64'(0));
        s_ack = 1'b0;
        cycle();

        // reset in the middle of an M1 transfer
        m1_cyc = 1'b1; m1_stb = 1'b1;
        cycle();
        cycle();
        check("t6_m1_grant", 64'(o_grant), 64'(2'b10));
        rst = 1'b1;
        cycle();
        rst = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        cycle();
        check("t6_outputs_zero", 64'({o_grant, o_scyc, o_sstb, o_ack, o_err}), 64'(0));
        s_ack = 1'b1;
        cycle();
        check("t6_m0_wins", 64'(o_grant), 64'(2'b01));
        drive_idle();
        cycle();
        cycle();

        // random traffic against the model
        left0 = 0; left1 = 0; stuck = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (left0 == 0 && $urandom_range(0, 3) == 0) left0 = $urandom_range(1, 3);
            if (left1 == 0 && $urandom_range(0, 3) == 0) left1 = $urandom_range(1, 3);
            m0_cyc = (left0 > 0); m0_stb = m0_cyc && ($urandom_range(0, 4) != 0);
            m1_cyc = (left1 > 0); m1_stb = m1_cyc && ($urandom_range(0, 4) != 0);
            m0_adr = $urandom; m0_wdat = $urandom; m0_we = 1'($urandom_range(0, 1));
            m1_adr = $urandom; m1_wdat = $urandom; m1_we = 1'($urandom_range(0, 1));
            m0_sel = 4'($urandom_range(0, 15)); m1_sel = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) == 0) stuck = ~stuck;
            if (mdl_owner >= 0) s_ack = !stuck && ($urandom_range(0, 2) == 0);
            else s_ack = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 249) == 0);
            cycle();
            if (exp_ack_g[0] && m0_stb && left0 > 0) left0--;
            if (exp_ack_g[1] && m1_stb && left1 > 0) left1--;
            if (exp_err_g[0] && $urandom_range(0, 1) == 0) left0 = 0;
            if (exp_err_g[1] && $urandom_range(0, 1) == 0) left1 = 0;
        end
        rst = 1'b0;

        // report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
